cp0_exc: RTL and testbench
==========================

CP0_EXC -- requirements
Module: cp0_exc

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
REQ-002 CLK  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 pc  in  32  PC of the instruction currently committing.
REQ-005 in_delay_slot  in  1  committing instruction is in a branch delay slot.
REQ-006 pc_write  in  1  fetch PC update enable; 1 = PC register samples its next value this edge.
REQ-007 exc_adel_if, exc_ri, exc_sys, exc_bp, exc_ov, exc_adel, exc_ades  in  1 each  exception flags for the committing instruction.
REQ-008 bad_vaddr  in  32  faulting address for the AdEL/AdES exceptions.
REQ-009 hw_int  in  6  external interrupt lines, level-sensitive.
REQ-010 eret  in  1  committing instruction is ERET.
REQ-011 mtc0  in  1  write enable; cp0_addr  in  5; wdata  in  32.
REQ-012 rdata  out  32  combinational read of the register selected by cp0_addr.
REQ-013 except  out  1  exception request to the PC register (PC loads 0xbfc00380 when except and pc_write are both 1).
REQ-014 Epc  out  32  current EPC register value, the ERET return target.
REQ-015 exl  out  1  Status.EXL.

Function
REQ-016 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); any other cp0_addr SHALL read 0 and ignore writes.
REQ-017 Interrupt pending = Status.IE & !Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]); Cause.IP[7:2] tracks hw_int each cycle (IP[7] is ORed with TI when CP0_TIMER_EN is defined).
REQ-018 Priority, highest first: Int(0), AdEL fetch(4), RI(10), Sys(8), Bp(9), Ov(12), AdEL data(4), AdES(5); only the highest is recorded.
REQ-019 FSM states RUN and HOLD; reset state RUN.
REQ-020 RUN: on any exception or a pending interrupt, in the same edge write Cause.ExcCode, Cause.BD=in_delay_slot, EPC=in_delay_slot?pc-4:pc (EPC and BD are left unchanged if EXL was already 1), Status.EXL=1, and BadVAddr (=pc for fetch AdEL, =bad_vaddr for data AdEL/AdES); then enter HOLD.
REQ-021 except SHALL be 1 exactly in HOLD (a registered output, 1 cycle after detection); HOLD SHALL return to RUN on the first edge with pc_write=1, and remain in HOLD while pc_write=0.
REQ-022 Exception flags and eret SHALL be ignored while in HOLD.
REQ-023 eret in RUN with no exception: Status.EXL cleared on that edge, provided pc_write=1; otherwise it has no effect.
REQ-024 Exception and eret in the same cycle: the exception wins and EXL stays 1.
REQ-025 Exception and mtc0 in the same cycle: the mtc0 write is dropped.
REQ-026 mtc0 writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC, Count and Compare all 32 bits. BadVAddr and Status.BEV (bit 22, reads 1) are read-only.
REQ-027 EPC arithmetic is modulo 2^32 (pc=0 in a delay slot gives 0xfffffffc).

Reset
REQ-028 While reset=0: Status=0x00400000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, FSM=RUN, except=0. rdata then follows REQ-016 immediately.
REQ-029 If reset asserts while in HOLD, except SHALL drop asynchronously and the exception SHALL be lost.

Configuration
REQ-030 With CP0_TIMER_EN defined:
- Count SHALL increment by 1 every second cycle (an internal toggle, reset to 0) and wrap modulo 2^32.
- Cause.TI (bit 30) SHALL set when Count==Compare.
- mtc0 to Compare SHALL clear TI.
- TI SHALL be ORed into IP[7].
REQ-031 Without CP0_TIMER_EN: Count, Compare and TI SHALL be absent; addresses 9 and 11 read 0, and bit 30 reads 0.

Verification
REQ-032 Release reset, then read cp0_addr=12 -> rdata=0x00400000, except=0, Epc=0.
REQ-033 exc_sys=1 at pc=0x80001000, in_delay_slot=1, pc_write=1 -> next cycle except=1, Epc=0x80000ffc, Cause.ExcCode=8, BD=1, exl=1; one cycle later except=0.
REQ-034 exc_ov with pc_write held 0 for 3 cycles -> except stays 1 for all 3 cycles and clears on the edge after pc_write=1; a second exc_ri during HOLD leaves Cause.ExcCode=12.
REQ-035 Write Status=0x00000401, then hw_int[0]=1 -> except=1 and ExcCode=0; a subsequent eret with pc_write=1 -> exl=0.
REQ-036 exc_adel (bad_vaddr=0x1235) together with eret and mtc0 to EPC -> ExcCode=4, BadVAddr=0x1235, EPC=pc, exl=1.
REQ-037 (CP0_TIMER_EN) Compare=4 and Count=0 -> TI set after 8 cycles; IP[7]=1; an mtc0 to Compare clears TI.

Source files
------------

// File: rtl/cp0_exc.sv
// MIPS CP0 exception/interrupt block: BadVAddr, Status, Cause, EPC and an optional timer.
// Define CP0_TIMER_EN to include Count/Compare and the Cause.TI timer interrupt.
module cp0_exc (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        in_delay_slot,
  input  logic        pc_write,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_ov,
  input  logic        exc_adel,
  input  logic        exc_ades,
  input  logic [31:0] bad_vaddr,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  input  logic        mtc0,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        except,
  output logic [31:0] Epc,
  output logic        exl
);

  localparam logic [4:0] AddrBadVAddr = 5'd8;
  localparam logic [4:0] AddrCount    = 5'd9;
  localparam logic [4:0] AddrCompare  = 5'd11;
  localparam logic [4:0] AddrStatus   = 5'd12;
  localparam logic [4:0] AddrCause    = 5'd13;
  localparam logic [4:0] AddrEpc      = 5'd14;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;
  localparam logic [4:0] ExcSys  = 5'd8;
  localparam logic [4:0] ExcBp   = 5'd9;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  typedef enum logic {StRun, StHold} state_e;

  typedef enum logic [1:0] {BadNone, BadPc, BadData} bad_sel_e;

  state_e      state_q, state_d;
  logic [7:0]  status_im_q, status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q, status_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_hw_q;
  logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        ti;
  logic [7:0]  ip;
  logic        int_pend;
  logic        any_exc;
  logic        take;
  logic        wr;
  logic [4:0]  exc_code;
  bad_sel_e    bad_sel;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q;
  logic        ti_q, ti_d;

  assign ti = ti_q;
`else
  assign ti = 1'b0;
`endif

  assign ip       = {cause_ip_hw_q[5] | ti, cause_ip_hw_q[4:0], cause_ip_sw_q};
  assign int_pend = status_ie_q & ~status_exl_q & (|(ip & status_im_q));
  assign any_exc  = int_pend | exc_adel_if | exc_ri | exc_sys | exc_bp | exc_ov |
                    exc_adel | exc_ades;
  assign take     = (state_q == StRun) & any_exc;
  // A committing exception squashes its own mtc0.
  assign wr       = mtc0 & ~take;

  always_comb begin
    exc_code = ExcInt;
    bad_sel  = BadNone;
    if (int_pend) begin
      exc_code = ExcInt;
    end else if (exc_adel_if) begin
      exc_code = ExcAdEL;
      bad_sel  = BadPc;
    end else if (exc_ri) begin
      exc_code = ExcRi;
    end else if (exc_sys) begin
      exc_code = ExcSys;
    end else if (exc_bp) begin
      exc_code = ExcBp;
    end else if (exc_ov) begin
      exc_code = ExcOv;
    end else if (exc_adel) begin
      exc_code = ExcAdEL;
      bad_sel  = BadData;
    end else if (exc_ades) begin
      exc_code = ExcAdES;
      bad_sel  = BadData;
    end
  end

  always_comb begin
    state_d       = state_q;
    status_im_d   = status_im_q;
    status_exl_d  = status_exl_q;
    status_ie_d   = status_ie_q;
    cause_bd_d    = cause_bd_q;
    cause_ip_sw_d = cause_ip_sw_q;
    cause_exc_d   = cause_exc_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;

    unique case (state_q)
      StRun:  if (take) state_d = StHold;
      StHold: if (pc_write) state_d = StRun;
      default: state_d = StRun;
    endcase

    if (wr) begin
      unique case (cp0_addr)
        AddrStatus: begin
          status_im_d  = wdata[15:8];
          status_exl_d = wdata[1];
          status_ie_d  = wdata[0];
        end
        AddrCause: cause_ip_sw_d = wdata[9:8];
        AddrEpc:   epc_d         = wdata;
        default: ;
      endcase
    end

    if (take) begin
      cause_exc_d  = exc_code;
      status_exl_d = 1'b1;
      // Nested exceptions keep the original return point.
      if (!status_exl_q) begin
        cause_bd_d = in_delay_slot;
        epc_d      = in_delay_slot ? pc - 32'd4 : pc;
      end
      if (bad_sel == BadPc) begin
        badvaddr_d = pc;
      end else if (bad_sel == BadData) begin
        badvaddr_d = bad_vaddr;
      end
    end else if ((state_q == StRun) && eret && pc_write) begin
      status_exl_d = 1'b0;
    end
  end

`ifdef CP0_TIMER_EN
  always_comb begin
    count_d   = tick_q ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q | (count_q == compare_q);
    if (wr && (cp0_addr == AddrCount)) begin
      count_d = wdata;
    end
    if (wr && (cp0_addr == AddrCompare)) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      compare_q <= '0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= ~tick_q;
      ti_q      <= ti_d;
    end
  end
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      status_im_q   <= '0;
      status_exl_q  <= 1'b0;
      status_ie_q   <= 1'b0;
      cause_bd_q    <= 1'b0;
      cause_ip_hw_q <= '0;
      cause_ip_sw_q <= '0;
      cause_exc_q   <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
    end else begin
      state_q       <= state_d;
      status_im_q   <= status_im_d;
      status_exl_q  <= status_exl_d;
      status_ie_q   <= status_ie_d;
      cause_bd_q    <= cause_bd_d;
      cause_ip_hw_q <= hw_int;
      cause_ip_sw_q <= cause_ip_sw_d;
      cause_exc_q   <= cause_exc_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (cp0_addr)
      AddrBadVAddr: rdata = badvaddr_q;
      AddrStatus:   rdata = {9'b0, 1'b1, 6'b0, status_im_q, 6'b0, status_exl_q, status_ie_q};
      AddrCause:    rdata = {cause_bd_q, ti, 14'b0, ip, 1'b0, cause_exc_q, 2'b0};
      AddrEpc:      rdata = epc_q;
`ifdef CP0_TIMER_EN
      AddrCount:    rdata = count_q;
      AddrCompare:  rdata = compare_q;
`endif
      default:      rdata = '0;
    endcase
  end

  assign except = (state_q == StHold);
  assign Epc    = epc_q;
  assign exl    = status_exl_q;

endmodule

// File: tb/tb_cp0_exc.sv
// Directed self-checking bench for cp0_exc.
module tb_cp0_exc;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic        in_delay_slot = 1'b0;
  logic        pc_write = 1'b0;
  logic        exc_adel_if = 1'b0, exc_ri = 1'b0, exc_sys = 1'b0, exc_bp = 1'b0;
  logic        exc_ov = 1'b0, exc_adel = 1'b0, exc_ades = 1'b0;
  logic [31:0] bad_vaddr = '0;
  logic [5:0]  hw_int = '0;
  logic        eret = 1'b0;
  logic        mtc0 = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        except;
  logic [31:0] Epc;
  logic        exl;

  int n_assert = 0;
  int n_fail = 0;

  cp0_exc dut (
    .CLK(CLK), .reset(reset), .pc(pc), .in_delay_slot(in_delay_slot), .pc_write(pc_write),
    .exc_adel_if(exc_adel_if), .exc_ri(exc_ri), .exc_sys(exc_sys), .exc_bp(exc_bp),
    .exc_ov(exc_ov), .exc_adel(exc_adel), .exc_ades(exc_ades), .bad_vaddr(bad_vaddr),
    .hw_int(hw_int), .eret(eret), .mtc0(mtc0), .cp0_addr(cp0_addr), .wdata(wdata),
    .rdata(rdata), .except(except), .Epc(Epc), .exl(exl)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {exc_adel_if, exc_ri, exc_sys, exc_bp, exc_ov, exc_adel, exc_ades} = '0;
    eret = 1'b0;
    mtc0 = 1'b0;
    in_delay_slot = 1'b0;
  endtask

  task automatic wr_cp0(input logic [4:0] a, input logic [31:0] d);
    mtc0 = 1'b1; cp0_addr = a; wdata = d;
    step();
    mtc0 = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = rdata;
  endtask

  initial begin
    logic [31:0] v;
    bit          seen;

    // Reset state, checked while reset is held low
    #12;
    rd(5'd12, v); chk("rst_status", v, 32'h0040_0000);
    chk("rst_except", {31'b0, except}, 32'd0);
    reset = 1'b1;
    #10;
    step();
    rd(5'd12, v); chk("status_after_rst", v, 32'h0040_0000);
    chk("except_after_rst", {31'b0, except}, 32'd0);
    chk("epc_after_rst", Epc, 32'd0);
    rd(5'd31, v); chk("unmapped_read", v, 32'd0);

    // Syscall in a delay slot
    pc = 32'h8000_1000; in_delay_slot = 1'b1; pc_write = 1'b1; exc_sys = 1'b1;
    step();
    clr();
    chk("sys_except", {31'b0, except}, 32'd1);
    chk("sys_epc", Epc, 32'h8000_0ffc);
    rd(5'd13, v);
    chk("sys_code", {27'b0, v[6:2]}, 32'd8);
    chk("sys_bd", {31'b0, v[31]}, 32'd1);
    chk("sys_exl", {31'b0, exl}, 32'd1);
    step();
    chk("sys_except_drop", {31'b0, except}, 32'd0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("eret_clear", {31'b0, exl}, 32'd0);

    // Overflow held by pc_write=0; RI during HOLD is ignored
    pc = 32'h8000_2000; pc_write = 1'b0; exc_ov = 1'b1;
    step();
    clr();
    chk("ov_hold1", {31'b0, except}, 32'd1);
    exc_ri = 1'b1;
    step();
    chk("ov_hold2", {31'b0, except}, 32'd1);
    step();
    chk("ov_hold3", {31'b0, except}, 32'd1);
    clr();
    rd(5'd13, v); chk("ov_code", {27'b0, v[6:2]}, 32'd12);
    chk("ov_epc", Epc, 32'h8000_2000);
    pc_write = 1'b1;
    step();
    chk("ov_release", {31'b0, except}, 32'd0);
    eret = 1'b1;
    step();
    eret = 1'b0;

    // Hardware interrupt
    wr_cp0(5'd12, 32'h0000_0401);
    rd(5'd12, v); chk("status_wr", v, 32'h0040_0401);
    hw_int = 6'b000001;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      seen = except;
    end
    hw_int = '0;
    chk("int_except", {31'b0, except}, 32'd1);
    rd(5'd13, v); chk("int_code", {27'b0, v[6:2]}, 32'd0);
    chk("int_exl", {31'b0, exl}, 32'd1);
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("int_eret_exl", {31'b0, exl}, 32'd0);
    chk("int_no_retrigger", {31'b0, except}, 32'd0);

    // eret needs pc_write
    wr_cp0(5'd12, 32'h0000_0403);
    pc_write = 1'b0; eret = 1'b1;
    step();
    chk("eret_nopcw", {31'b0, exl}, 32'd1);
    pc_write = 1'b1;
    step();
    eret = 1'b0;
    chk("eret_pcw", {31'b0, exl}, 32'd0);
    wr_cp0(5'd12, 32'h0000_0000);

    // Data AdEL with eret and mtc0 EPC in the same cycle
    pc = 32'h8000_3000; exc_adel = 1'b1; bad_vaddr = 32'h1235; eret = 1'b1;
    mtc0 = 1'b1; cp0_addr = 5'd14; wdata = 32'hdead_beef;
    step();
    clr();
    chk("adel_except", {31'b0, except}, 32'd1);
    rd(5'd13, v); chk("adel_code", {27'b0, v[6:2]}, 32'd4);
    rd(5'd8, v); chk("adel_badv", v, 32'h1235);
    chk("adel_epc", Epc, 32'h8000_3000);
    chk("adel_exl", {31'b0, exl}, 32'd1);
    step();

    // Nested exception: priority RI over Bp/AdES; EPC and BD kept
    pc = 32'h8000_4000; in_delay_slot = 1'b1;
    exc_ri = 1'b1; exc_bp = 1'b1; exc_ades = 1'b1;
    step();
    clr();
    rd(5'd13, v);
    chk("prio_code", {27'b0, v[6:2]}, 32'd10);
    chk("nested_bd", {31'b0, v[31]}, 32'd0);
    chk("nested_epc", Epc, 32'h8000_3000);
    step();

    // Fetch AdEL outranks data AdEL; BadVAddr takes pc
    pc = 32'h8000_5000; exc_adel_if = 1'b1; exc_adel = 1'b1; bad_vaddr = 32'h55;
    step();
    clr();
    rd(5'd13, v); chk("adelif_code", {27'b0, v[6:2]}, 32'd4);
    rd(5'd8, v); chk("adelif_badv", v, 32'h8000_5000);
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;

    // EPC wraps for pc=0 in a delay slot
    pc = 32'h0; in_delay_slot = 1'b1; exc_bp = 1'b1;
    step();
    clr();
    chk("wrap_epc", Epc, 32'hffff_fffc);
    rd(5'd13, v); chk("bp_code", {27'b0, v[6:2]}, 32'd9);
    step();

    // Register write masks
    wr_cp0(5'd14, 32'h1234_5678);
    chk("epc_wr", Epc, 32'h1234_5678);
    wr_cp0(5'd8, 32'h0);
    rd(5'd8, v); chk("badv_ro", v, 32'h8000_5000);
    wr_cp0(5'd13, 32'hffff_ffff);
    rd(5'd13, v); chk("cause_sw_ip", {30'b0, v[9:8]}, 32'd3);
    wr_cp0(5'd12, 32'hffff_ffff);
    rd(5'd12, v); chk("status_mask", v, 32'h0040_ff03);
    wr_cp0(5'd9, 32'h0000_1234);
`ifdef CP0_TIMER_EN
    rd(5'd9, v); chk("count_wr", {31'b0, v >= 32'h1234 && v <= 32'h1235}, 32'd1);
`else
    rd(5'd9, v); chk("count_absent", v, 32'd0);
    rd(5'd13, v); chk("ti_absent", {31'b0, v[30]}, 32'd0);
`endif

    // Async reset during HOLD
    pc = 32'h8000_6000; exc_sys = 1'b1;
    step();
    clr();
    chk("pre_rst_hold", {31'b0, except}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_except", {31'b0, except}, 32'd0);
    rd(5'd12, v); chk("async_rst_status", v, 32'h0040_0000);
    chk("async_rst_epc", Epc, 32'd0);
    #2 reset = 1'b1;
    step();
    chk("rst_exc_lost", {31'b0, except}, 32'd0);

`ifdef CP0_TIMER_EN
    wr_cp0(5'd11, 32'd4);
    wr_cp0(5'd9, 32'd0);
    rd(5'd13, v); chk("ti_cleared", {31'b0, v[30]}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      rd(5'd13, v);
      seen = v[30];
    end
    chk("ti_set", {31'b0, v[30]}, 32'd1);
    chk("ip7_ti", {31'b0, v[15]}, 32'd1);
    wr_cp0(5'd11, 32'd100);
    rd(5'd13, v); chk("ti_clr_cmp", {31'b0, v[30]}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
